proc_control: RTL and testbench
===============================

Name: proc_control

Overview:
- Multi-cycle control FSM for the basic CPU datapath.
- Each cycle it drives the 4-bit bus-mux select, the register load enables (R0..R7, A, G, IR) and the ALU operation.
- It sequences one 9-bit instruction per run request and pulses done on completion.
- Sits beside the bus mux and register file; IR is an external register loaded from din under irin.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- SEL_G, 8, mux select code for register G.
- SEL_DIN, 9, mux select code for din.
- SEL_NONE, 15, mux select code that clears the bus (any code > 9).

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  start request; sampled only in state T0.
- ir  input  9  instruction from IR: [8:6]=opcode III, [5:3]=Rx, [2:0]=Ry.
- select  output  4  bus-mux select: 0..7 selects R0..R7, 8 selects G, 9 selects din.
- rin  output  8  one-hot load enable for R0..R7.
- ain  output  1  load enable for A.
- gin  output  1  load enable for G.
- irin  output  1  load enable for IR (loads from din).
- alu_op  output  2  ALU operation: 00 add, 01 sub, 10 and.
- done  output  1  one-cycle pulse in the final cycle of an instruction.
- busy  output  1  high when state is not T0.
- icount  output  CNT_W  count of completed instructions.

Behaviour:
- States: T0 (idle/fetch), T1, T2, T3. State register encoded in 2 bits.
- Outputs are combinational from state and ir. Default values: select=SEL_NONE, rin=0, ain=gin=irin=done=0, alu_op=00.
- While reset is high, outputs are forced to their defaults regardless of state.
- On a clock edge with reset high: state<=T0, icount<=0.
- T0:
  - run=0: defaults; stay in T0.
  - run=1: irin=1, select=SEL_DIN; next state T1.
  - ir is valid from T1 onward and must be held stable by IR until the next T0.
- T1, decoded on ir[8:6]:
  - 000 mv Rx,Ry: select=Ry, rin[Rx]=1, done=1; next state T0.
  - 001 mvi Rx,#D: select=SEL_DIN, rin[Rx]=1, done=1; next state T0. The immediate is supplied on din during this cycle.
  - 010 add, 011 sub, 100 and: select=Rx, ain=1; next state T2.
  - 101, 110, 111 (undefined): treated as nop. done=1, select=SEL_NONE, nothing loaded; next state T0.
- T2: select=Ry, gin=1, alu_op = 00 for add, 01 for sub, 10 for and; next state T3.
- T3: select=SEL_G, rin[Rx]=1, done=1; next state T0.
- Latency from run sampled high in T0:
  - mv, mvi, nop: done in the 2nd cycle.
  - add, sub, and: done in the 4th cycle.
- Back-to-back: the cycle after done is T0, so run may be high there. Minimum inter-instruction gap is one T0 fetch cycle.
- run is ignored in T1..T3; no queuing.
- rin is always one-hot or zero. At most one of rin, ain, gin, irin groups is active per cycle.
- icount increments by 1 on every edge where done=1 and reset=0. It wraps from 2^CNT_W-1 to 0.
- Rx=Ry is legal; e.g. add R3,R3 doubles R3.
- Reset mid-instruction (T1..T3): the instruction is abandoned and no done is generated for it. Register writes already committed remain.
- busy = (state != T0). busy is 0 during reset.

Test Plan:
1. Reset held 2 cycles from any state -> state T0, select=15, all enables 0, icount=0, busy=0.
2. run=1 with din=9'b001_010_000 (mvi R2), then din=0x00A5 next cycle -> T0: irin=1, select=9. T1: select=9, rin=8'b00000100, done=1. icount=1.
3. R1=5, R6=3, ir=add R1,R6 -> T1: select=1, ain=1. T2: select=6, gin=1, alu_op=00. T3: select=8, rin=8'b00000010, done=1. R1 ends at 8.
4. sub R4,R4 with R4=0x0010 -> alu_op=01 in T2; R4 ends at 0. Then ir=mv R0,R4 issued the cycle after done -> select=4, rin[0]=1 in T1; icount increments twice.
5. Opcode 111 -> T1 asserts done=1 with select=15 and no enables; no register changes. run held high through T1..T3 of an add does not restart the FSM.
6. reset asserted in T2 of add -> no gin on the following cycles, no done, state T0. Preload icount path to 0xFFFF and complete one mv -> icount=0x0000.

Source files
------------

// File: rtl/proc_control.sv
// Multi-cycle control FSM for the basic CPU datapath: drives the bus-mux select,
// register load enables and ALU op while sequencing one 9-bit instruction per run.
module proc_control #(
    parameter int         CNT_W    = 16,
    parameter logic [3:0] SEL_G    = 4'd8,
    parameter logic [3:0] SEL_DIN  = 4'd9,
    parameter logic [3:0] SEL_NONE = 4'd15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [8:0]       ir,
    output logic [3:0]       select,
    output logic [7:0]       rin,
    output logic             ain,
    output logic             gin,
    output logic             irin,
    output logic [1:0]       alu_op,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;

    state_t     state, state_nxt;
    logic [2:0] opc, rx, ry;
    logic [7:0] rx_oh;

    assign opc   = ir[8:6];
    assign rx    = ir[5:3];
    assign ry    = ir[2:0];
    assign rx_oh = 8'd1 << rx;

    // Outputs are purely combinational so the datapath sees them in the same cycle.
    always_comb begin
        select    = SEL_NONE;
        rin       = '0;
        ain       = 1'b0;
        gin       = 1'b0;
        irin      = 1'b0;
        alu_op    = 2'b00;
        done      = 1'b0;
        state_nxt = state;
        if (!reset) begin
            case (state)
                T0: begin
                    if (run) begin
                        irin      = 1'b1;
                        select    = SEL_DIN;
                        state_nxt = T1;
                    end
                end
                T1: begin
                    case (opc)
                        OP_MV: begin
                            select    = {1'b0, ry};
                            rin       = rx_oh;
                            done      = 1'b1;
                            state_nxt = T0;
                        end
                        OP_MVI: begin
                            select    = SEL_DIN;
                            rin       = rx_oh;
                            done      = 1'b1;
                            state_nxt = T0;
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            select    = {1'b0, rx};
                            ain       = 1'b1;
                            state_nxt = T2;
                        end
                        default: begin
                            // Undefined opcodes retire as a nop.
                            done      = 1'b1;
                            state_nxt = T0;
                        end
                    endcase
                end
                T2: begin
                    select    = {1'b0, ry};
                    gin       = 1'b1;
                    case (opc)
                        OP_SUB:  alu_op = 2'b01;
                        OP_AND:  alu_op = 2'b10;
                        default: alu_op = 2'b00;
                    endcase
                    state_nxt = T3;
                end
                T3: begin
                    select    = SEL_G;
                    rin       = rx_oh;
                    done      = 1'b1;
                    state_nxt = T0;
                end
                default: state_nxt = T0;
            endcase
        end
    end

    assign busy = !reset && (state != T0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= T0;
            icount <= '0;
        end else begin
            state <= state_nxt;
            if (done)
                icount <= icount + 1'b1;
        end
    end

endmodule

// File: tb/tb_proc_control.sv
// Bench for proc_control: a small datapath model (IR, R0..R7, A, G) plus a
// per-cycle expected-control scoreboard for each instruction issued.
module tb_proc_control;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] rin;
        logic       ain;
        logic       gin;
        logic       irin;
        logic [1:0] alu;
        logic       done;
        logic       busy;
    } ctl_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run   = 1'b0;
    logic [15:0] din   = '0;
    logic [8:0]  ir_q  = '0;

    logic [3:0]  select, select4;
    logic [7:0]  rin, rin4;
    logic        ain, gin, irin, done, busy;
    logic        ain4, gin4, irin4, done4, busy4;
    logic [1:0]  alu_op, alu_op4;
    logic [15:0] icount;
    logic [3:0]  icount4;

    logic [15:0] r [8];
    logic [15:0] a_reg = '0, g_reg = '0, bus;

    ctl_t exp_q[$];
    ctl_t obs_q[$];
    ctl_t obs;
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;

    always #5 clock = ~clock;

    proc_control dut (
        .clock(clock), .reset(reset), .run(run), .ir(ir_q),
        .select(select), .rin(rin), .ain(ain), .gin(gin), .irin(irin),
        .alu_op(alu_op), .done(done), .busy(busy), .icount(icount)
    );

    // Narrow counter instance so wrap-around is reachable in a short run.
    proc_control #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .run(run), .ir(ir_q),
        .select(select4), .rin(rin4), .ain(ain4), .gin(gin4), .irin(irin4),
        .alu_op(alu_op4), .done(done4), .busy(busy4), .icount(icount4)
    );

    assign obs = {select, rin, ain, gin, irin, alu_op, done, busy};

    always_comb begin
        if (select < 4'd8)       bus = r[select[2:0]];
        else if (select == 4'd8) bus = g_reg;
        else if (select == 4'd9) bus = din;
        else                     bus = '0;
    end

    initial for (int i = 0; i < 8; i++) r[i] = '0;

    always @(posedge clock) begin
        for (int i = 0; i < 8; i++)
            if (rin[i]) r[i] <= bus;
        if (ain) a_reg <= bus;
        if (gin)
            case (alu_op)
                2'b00:   g_reg <= a_reg + bus;
                2'b01:   g_reg <= a_reg - bus;
                2'b10:   g_reg <= a_reg & bus;
                default: g_reg <= 'x;
            endcase
        if (irin) ir_q <= din[8:0];
    end

    function automatic ctl_t mk(input logic [3:0] sel, input logic [7:0] rn,
                                input logic a, input logic g, input logic i,
                                input logic [1:0] op, input logic d, input logic b);
        mk = {sel, rn, a, g, i, op, d, b};
    endfunction

    // Expected control word for every cycle of one instruction, T0 fetch included.
    task automatic push_instr(input logic [8:0] ins);
        logic [2:0] opc, rx, ry;
        logic [7:0] oh;
        opc = ins[8:6];
        rx  = ins[5:3];
        ry  = ins[2:0];
        oh  = 8'd1 << rx;
        exp_q.push_back(mk(4'd9, 8'h00, 0, 0, 1, 2'b00, 0, 0));
        case (opc)
            3'b000: exp_q.push_back(mk({1'b0, ry}, oh, 0, 0, 0, 2'b00, 1, 1));
            3'b001: exp_q.push_back(mk(4'd9, oh, 0, 0, 0, 2'b00, 1, 1));
            3'b010, 3'b011, 3'b100: begin
                exp_q.push_back(mk({1'b0, rx}, 8'h00, 1, 0, 0, 2'b00, 0, 1));
                exp_q.push_back(mk({1'b0, ry}, 8'h00, 0, 1, 0,
                    (opc == 3'b010) ? 2'b00 : (opc == 3'b011) ? 2'b01 : 2'b10, 0, 1));
                exp_q.push_back(mk(4'd8, oh, 0, 0, 0, 2'b00, 1, 1));
            end
            default: exp_q.push_back(mk(4'd15, 8'h00, 0, 0, 0, 2'b00, 1, 1));
        endcase
        exp_cnt++;
    endtask

    // Drives one instruction from T0 until done (bounded), recording observed controls.
    task automatic issue(input logic [8:0] ins, input logic [15:0] imm, input logic hold_run);
        logic sdone;
        push_instr(ins);
        run = 1'b1;
        din = {7'd0, ins};
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            obs_q.push_back(obs);
            sdone = done;
            @(posedge clock); #1;
            run = hold_run;
            din = imm;
            if (sdone) break;
        end
        run = 1'b0;
        din = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b1;
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (obs !== mk(4'd15, 8'h00, 0, 0, 0, 2'b00, 0, 0)) begin
                errors++; $display("FAIL reset_ctl got %h want %h", obs, mk(4'd15, 8'h00, 0, 0, 0, 2'b00, 0, 0));
            end
        end
        @(posedge clock); #1;
        reset = 1'b0;
        run   = 1'b0;
        exp_cnt = 0;
        @(negedge clock);
        checks++;
        if (obs !== mk(4'd15, 8'h00, 0, 0, 0, 2'b00, 0, 0) || icount !== 16'd0) begin
            errors++; $display("FAIL reset_idle got ctl=%h icount=%h want ctl=%h icount=0", obs, icount, mk(4'd15, 8'h00, 0, 0, 0, 2'b00, 0, 0));
        end
        @(posedge clock); #1;
    endtask

    task automatic test_mvi();
        ctl_t e, o;
        issue(9'b001_010_000, 16'h00A5, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL mvi_ctl got %h want %h", o, e); end
        end
        obs_q.delete();
        @(negedge clock);
        checks++;
        if (icount !== 16'(exp_cnt) || r[2] !== 16'h00A5) begin
            errors++; $display("FAIL mvi_result got icount=%0d R2=%h want icount=%0d R2=00a5", icount, r[2], exp_cnt);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_add();
        ctl_t e, o;
        issue(9'b001_001_000, 16'd5, 1'b0);
        issue(9'b001_110_000, 16'd3, 1'b0);
        issue(9'b010_001_110, 16'd0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL add_ctl got %h want %h", o, e); end
        end
        obs_q.delete();
        @(negedge clock);
        checks++;
        if (r[1] !== 16'd8 || icount !== 16'(exp_cnt)) begin
            errors++; $display("FAIL add_result got R1=%h icount=%0d want R1=0008 icount=%0d", r[1], icount, exp_cnt);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        ctl_t e, o;
        issue(9'b001_000_000, 16'h0077, 1'b0);
        issue(9'b001_100_000, 16'h0010, 1'b0);
        issue(9'b011_100_100, 16'd0, 1'b0);
        issue(9'b000_000_100, 16'd0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_ctl got %h want %h", o, e); end
        end
        obs_q.delete();
        @(negedge clock);
        checks++;
        if (r[4] !== 16'd0 || r[0] !== 16'd0 || icount !== 16'(exp_cnt)) begin
            errors++; $display("FAIL b2b_result got R4=%h R0=%h icount=%0d want 0000 0000 %0d", r[4], r[0], icount, exp_cnt);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_nop_run_hold();
        ctl_t e, o;
        logic [15:0] snap [8];
        for (int i = 0; i < 8; i++) snap[i] = r[i];
        issue(9'b111_011_101, 16'hBEEF, 1'b0);
        issue(9'b010_010_010, 16'd0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL nop_hold_ctl got %h want %h", o, e); end
        end
        obs_q.delete();
        snap[2] = snap[2] + snap[2];
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (r[i] !== snap[i]) begin errors++; $display("FAIL nop_hold_reg R%0d got %h want %h", i, r[i], snap[i]); end
        end
        checks++;
        if (busy !== 1'b0 || icount !== 16'(exp_cnt)) begin
            errors++; $display("FAIL nop_hold_idle got busy=%b icount=%0d want busy=0 icount=%0d", busy, icount, exp_cnt);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid();
        logic [15:0] r1_before;
        r1_before = r[1];
        run = 1'b1;
        din = {7'd0, 9'b010_001_110};
        @(posedge clock); #1;
        run = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (gin !== 1'b1) begin errors++; $display("FAIL rst_mid_t2 got gin=%b want 1", gin); end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (obs !== mk(4'd15, 8'h00, 0, 0, 0, 2'b00, 0, 0)) begin
                errors++; $display("FAIL rst_mid_ctl got %h want %h", obs, mk(4'd15, 8'h00, 0, 0, 0, 2'b00, 0, 0));
            end
            @(posedge clock); #1;
        end
        reset = 1'b0;
        exp_cnt = 0;
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (obs !== mk(4'd15, 8'h00, 0, 0, 0, 2'b00, 0, 0) || icount !== 16'd0 || r[1] !== r1_before) begin
                errors++; $display("FAIL rst_mid_after got ctl=%h icount=%0d R1=%h want ctl=%h icount=0 R1=%h",
                                   obs, icount, r[1], mk(4'd15, 8'h00, 0, 0, 0, 2'b00, 0, 0), r1_before);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 15; k++) issue(9'b101_000_000, 16'd0, 1'b0);
        exp_q.delete();
        obs_q.delete();
        @(negedge clock);
        checks++;
        if (icount4 !== 4'd15 || icount !== 16'(exp_cnt)) begin
            errors++; $display("FAIL wrap_pre got icount4=%0d icount=%0d want 15 %0d", icount4, icount, exp_cnt);
        end
        @(posedge clock); #1;
        issue(9'b000_011_001, 16'd0, 1'b0);
        exp_q.delete();
        obs_q.delete();
        @(negedge clock);
        checks++;
        if (icount4 !== 4'd0 || icount !== 16'(exp_cnt)) begin
            errors++; $display("FAIL wrap got icount4=%0d icount=%0d want 0 %0d", icount4, icount, exp_cnt);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        @(posedge clock); #1;
        test_reset();
        test_mvi();
        test_add();
        test_back_to_back();
        test_nop_run_hold();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
